modsub_sched: RTL and testbench
===============================

Name: modsub_sched

Overview:
- Round-robin scheduler that shares one pipelined modsub datapath among NREQ requesters.
- Owns the modulus configuration register (qH) and drains the pipeline before any reconfiguration.
- Tags each issued operation with its requester id and returns results with that id after the fixed datapath latency.
- Sits between the NTT/poly-arithmetic lane controllers and a single modsub instance.

Parameters:
- NREQ, 4, number of requesters (2..16)
- LOGQ, 64, operand/result width; A and B are LOGQ wide
- LOGQH, 47, width of qH; q = qH*2^(LOGQ-LOGQH) + 1
- FF_IN, 1, modsub input register stage enable
- FF_SUB, 1, modsub subtract register stage enable
- FF_OUT, 1, modsub output register stage enable
- QH_RST, 47'd0, reset value of the qH register
- IDW, $clog2(NREQ), width of the requester id

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*LOGQ  packed minuends; requester i at [i*LOGQ +: LOGQ]
- req_b  in  NREQ*LOGQ  packed subtrahends, same packing
- cfg_we  in  1  request to load cfg_qh; held until accepted
- cfg_qh  in  LOGQH  new qH value
- cfg_busy  out  1  cfg_we is pending because the pipeline is not empty
- qh_cur  out  LOGQH  current qH register value
- res_valid  out  1  result valid pulse
- res_id  out  IDW  requester id of the result
- res_c  out  LOGQ  (A - B) mod q

Behaviour:
- Reset values: req_ready=0, cfg_busy=0, res_valid=0, res_id=0, qh_cur=QH_RST, rr pointer=0, tag pipeline cleared, inflight=0.
- LAT = FF_IN + FF_SUB + FF_OUT, computed with the shared latency function.
- Handshake:
  - Transfer on req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid, pointer and cfg state.
  - A requester must hold A, B and valid until accepted.
  - There is no result backpressure; consumers must accept res_valid pulses.
- Arbitration:
  - Grant the first i with req_valid[i]=1, scanning from ptr upward and wrapping modulo NREQ.
  - At most one grant per cycle.
  - After a grant to g, ptr <= (g+1) mod NREQ; otherwise ptr holds.
- Issue:
  - The granted operands drive modsub A and B directly.
  - Tag pipeline is a shift register of depth LAT holding {valid, id}.
  - A result issued on the edge at cycle k appears with res_valid=1 during cycle k+LAT.
  - res_c and res_id are valid only when res_valid=1.
  - If LAT=0, res_* is combinational in the issue cycle.
- inflight counter: +1 on issue, -1 on retire, both in the same cycle gives no change. Range 0..LAT.
- Configuration (cfg_we has priority over issue):
  - cfg_we=1 forces req_ready=0 for all requesters.
  - If inflight=0 and no retire this cycle, qh_cur <= cfg_qh on the next edge and cfg_busy=0.
  - Otherwise cfg_busy=1 and issue stays blocked until drained.
  - Consequence: qH is stable for every in-flight operation.
  - The first issue using the new qH is no earlier than the cycle after the load.
- Simultaneous cfg_we and req_valid: cfg wins, and ptr does not advance.
- Reset mid-operation: all in-flight tags are discarded and no res_valid is emitted for them. Datapath data registers need no reset.
- Width rules:
  - Operands are expected to be < q; behaviour for operands >= q is unspecified.
  - Result is always within LOGQ bits.

Decomposition:
- Shared modsub package holds modsub_params_t and the modsub latency function. The scheduler computes LAT from these; it is not duplicated locally.
- Sub-module rr_arbiter (parameter N): inputs req, ptr, en; outputs one-hot gnt and encoded gnt_id. It is reusable by the modadd/modmul schedulers.
- The scheduler instantiates modsub with LOGA=LOGB=LOGQ.

Test Plan:
- Basic subtraction: reset, cfg qh=1 (q=131073), req0 A=5 B=3 -> res_valid at issue+3 with res_id=0, res_c=2.
- Wrap case: A=3 B=5 on req2 -> res_c=131071, res_id=2. A=0 B=0 -> 0.
- Round-robin fairness: all four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, results in the same order, one per cycle after 3-cycle latency.
- Config drain: 3 ops in flight, then cfg_we with qh=2 -> cfg_busy=1 for 3 cycles, no grants, qh_cur=2 after drain. A=3 B=5 then returns 262143.
- Reset mid-flight: assert rst with 2 ops in flight -> no res_valid afterward, qh_cur=QH_RST, ptr=0. The next grant with all requests valid goes to req0.
- Latency sweep: FF_IN/FF_SUB/FF_OUT = 0/0/0 and 1/0/1 -> results at issue+0 and issue+2 respectively, values matching the reference model.

Source files
------------

// File: rtl/modsub_sched_pkg.sv
// Shared modsub definitions: pipeline-stage configuration and the latency it implies.
package modsub_sched_pkg;

  typedef struct packed {
    logic ff_in;
    logic ff_sub;
    logic ff_out;
  } modsub_params_t;

  function automatic int unsigned modsub_latency(input modsub_params_t p);
    return 32'(p.ff_in) + 32'(p.ff_sub) + 32'(p.ff_out);
  endfunction

endpackage

// File: rtl/modsub.sv
// Pipelined modular subtractor: c = (a - b) mod q, q = qh * 2^(LOGQ-LOGQH) + 1.
module modsub #(
  parameter int unsigned LOGA   = 64,
  parameter int unsigned LOGB   = 64,
  parameter int unsigned LOGQ   = 64,
  parameter int unsigned LOGQH  = 47,
  parameter bit          FF_IN  = 1'b1,
  parameter bit          FF_SUB = 1'b1,
  parameter bit          FF_OUT = 1'b1
) (
  input  logic             clk,
  input  logic [LOGA-1:0]  a,
  input  logic [LOGB-1:0]  b,
  input  logic [LOGQH-1:0] qh,
  output logic [LOGQ-1:0]  c
);

  logic [LOGQ-1:0] q, a_s, b_s, c_s;
  logic [LOGQ:0]   d_c, d_s;

  assign q = (LOGQ'(qh) << (LOGQ - LOGQH)) + LOGQ'(1);

  if (FF_IN) begin : g_in
    logic [LOGQ-1:0] a_q, b_q;
    always_ff @(posedge clk) begin
      a_q <= LOGQ'(a);
      b_q <= LOGQ'(b);
    end
    assign a_s = a_q;
    assign b_s = b_q;
  end else begin : g_no_in
    assign a_s = LOGQ'(a);
    assign b_s = LOGQ'(b);
  end

  assign d_c = {1'b0, a_s} - {1'b0, b_s};

  if (FF_SUB) begin : g_sub
    logic [LOGQ:0] d_q;
    always_ff @(posedge clk) d_q <= d_c;
    assign d_s = d_q;
  end else begin : g_no_sub
    assign d_s = d_c;
  end

  // On borrow, adding q wraps the low LOGQ bits back into [0, q).
  assign c_s = d_s[LOGQ] ? d_s[LOGQ-1:0] + q : d_s[LOGQ-1:0];

  if (FF_OUT) begin : g_out
    logic [LOGQ-1:0] c_q;
    always_ff @(posedge clk) c_q <= c_s;
    assign c = c_q;
  end else begin : g_no_out
    assign c = c_s;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    found  = 1'b0;
    if (en) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/modsub_sched.sv
// Round-robin scheduler sharing one modsub pipeline; owns qH and drains before reconfiguring.
module modsub_sched
  import modsub_sched_pkg::*;
#(
  parameter int unsigned      NREQ   = 4,
  parameter int unsigned      LOGQ   = 64,
  parameter int unsigned      LOGQH  = 47,
  parameter bit               FF_IN  = 1'b1,
  parameter bit               FF_SUB = 1'b1,
  parameter bit               FF_OUT = 1'b1,
  parameter logic [LOGQH-1:0] QH_RST = '0,
  parameter int unsigned      IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*LOGQ-1:0] req_a,
  input  logic [NREQ*LOGQ-1:0] req_b,
  input  logic                 cfg_we,
  input  logic [LOGQH-1:0]     cfg_qh,
  output logic                 cfg_busy,
  output logic [LOGQH-1:0]     qh_cur,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [LOGQ-1:0]      res_c
);

  localparam modsub_params_t MsCfg = '{ff_in: FF_IN, ff_sub: FF_SUB, ff_out: FF_OUT};
  localparam int unsigned    LAT   = modsub_latency(MsCfg);
  localparam int unsigned    CW    = $clog2(LAT + 2);

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id, ptr_q, ptr_d;
  logic [LOGQH-1:0] qh_q, qh_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [LOGQ-1:0]  op_a, op_b;
  logic             issue, retire, cfg_load;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (!cfg_we && !rst),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign issue     = |gnt;
  assign op_a      = req_a[32'(gnt_id) * LOGQ +: LOGQ];
  assign op_b      = req_b[32'(gnt_id) * LOGQ +: LOGQ];

  // A retiring op still counts as in flight until its result has left.
  assign cfg_load = cfg_we && (inflight_q == '0) && !retire;
  assign cfg_busy = cfg_we && !cfg_load;
  assign qh_cur   = qh_q;

  always_comb begin
    ptr_d      = ptr_q;
    qh_d       = qh_q;
    inflight_d = inflight_q + CW'(issue) - CW'(retire);
    if (issue) begin
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
    if (cfg_load) begin
      qh_d = cfg_qh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      qh_q       <= QH_RST;
      inflight_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      qh_q       <= qh_d;
      inflight_q <= inflight_d;
    end
  end

  if (LAT == 0) begin : g_tag_comb
    assign res_valid = issue;
    assign res_id    = gnt_id;
  end else begin : g_tag_pipe
    logic [LAT-1:0] tv_q;
    logic [IDW-1:0] tid_q [LAT];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tv_q <= '0;
        for (int i = 0; i < LAT; i++) tid_q[i] <= '0;
      end else begin
        tv_q[0]  <= issue;
        tid_q[0] <= gnt_id;
        for (int i = 1; i < LAT; i++) begin
          tv_q[i]  <= tv_q[i-1];
          tid_q[i] <= tid_q[i-1];
        end
      end
    end
    assign res_valid = tv_q[LAT-1];
    assign res_id    = tid_q[LAT-1];
  end

  assign retire = res_valid;

  modsub #(
    .LOGA   (LOGQ),
    .LOGB   (LOGQ),
    .LOGQ   (LOGQ),
    .LOGQH  (LOGQH),
    .FF_IN  (FF_IN),
    .FF_SUB (FF_SUB),
    .FF_OUT (FF_OUT)
  ) u_modsub (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .qh  (qh_q),
    .c   (res_c)
  );

endmodule

// File: tb/tb_modsub_sched.sv
// Three scheduler configurations (latency 3, 0, 2) checked every cycle against a queue model.
module tb_modsub_sched;

  localparam int N   = 4;
  localparam int LQ  = 64;
  localparam int LQH = 47;

  typedef struct {
    int          dut;
    int          due;
    int          id;
    logic [63:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    rv    [3];
  logic [N*LQ-1:0] ra    [3];
  logic [N*LQ-1:0] rb    [3];
  logic            cw    [3];
  logic [LQH-1:0]  cq    [3];
  logic [N-1:0]    rdy   [3];
  logic            busy  [3];
  logic [LQH-1:0]  qhc   [3];
  logic            resv  [3];
  logic [1:0]      resid [3];
  logic [LQ-1:0]   resc  [3];

  modsub_sched #(.NREQ(N), .LOGQ(LQ), .LOGQH(LQH), .FF_IN(1'b1), .FF_SUB(1'b1), .FF_OUT(1'b1))
  u_lat3 (.clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_a(ra[0]),
          .req_b(rb[0]), .cfg_we(cw[0]), .cfg_qh(cq[0]), .cfg_busy(busy[0]), .qh_cur(qhc[0]),
          .res_valid(resv[0]), .res_id(resid[0]), .res_c(resc[0]));

  modsub_sched #(.NREQ(N), .LOGQ(LQ), .LOGQH(LQH), .FF_IN(1'b0), .FF_SUB(1'b0), .FF_OUT(1'b0))
  u_lat0 (.clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_a(ra[1]),
          .req_b(rb[1]), .cfg_we(cw[1]), .cfg_qh(cq[1]), .cfg_busy(busy[1]), .qh_cur(qhc[1]),
          .res_valid(resv[1]), .res_id(resid[1]), .res_c(resc[1]));

  modsub_sched #(.NREQ(N), .LOGQ(LQ), .LOGQH(LQH), .FF_IN(1'b1), .FF_SUB(1'b0), .FF_OUT(1'b1))
  u_lat2 (.clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy[2]), .req_a(ra[2]),
          .req_b(rb[2]), .cfg_we(cw[2]), .cfg_qh(cq[2]), .cfg_busy(busy[2]), .qh_cur(qhc[2]),
          .res_valid(resv[2]), .res_id(resid[2]), .res_c(resc[2]));

  int             lat      [3];
  int             mptr     [3];
  logic [LQH-1:0] mqh      [3];
  logic [N-1:0]   acc      [3];
  bit             cfg_done [3];
  int             busy_cnt [3];
  int             iss_cyc  [3];
  int             res_cyc  [3];
  logic [63:0]    last_c   [3];
  int             last_id  [3];
  exp_t           expq     [$];
  int             cyc;
  int             n_chk;
  int             n_fail;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [63:0] ref_sub(logic [63:0] a, logic [63:0] b, logic [LQH-1:0] qh);
    logic [63:0] q;
    q = (64'(qh) << (LQ - LQH)) + 64'd1;
    if (a >= b) return a - b;
    return q - (b - a);
  endfunction

  function automatic logic [63:0] rand_op(logic [LQH-1:0] qh);
    logic [63:0] q, r;
    q = (64'(qh) << (LQ - LQH)) + 64'd1;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return q - 64'd1;
      default: return r % q;
    endcase
  endfunction

  function automatic logic [LQH-1:0] rand_qh();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return LQH'(1);
    if (r[LQH-1:0] == '0) return LQH'(1);
    return r[LQH-1:0];
  endfunction

  // Evaluates one DUT for the current cycle against the model, then advances the model.
  task automatic check_dut(int d);
    bit           pend = 0;
    int           gi = -1;
    int           hit = -1;
    logic [N-1:0] g = '0;
    exp_t         e;
    foreach (expq[k]) if (expq[k].dut == d && expq[k].due >= cyc) pend = 1;
    if (!cw[d] && !rst) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr[d] + k) % N;
        if (gi < 0 && rv[d][i]) gi = i;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    chk($sformatf("req_ready[%0d]", d), 64'(rdy[d]), 64'(g));
    chk($sformatf("cfg_busy[%0d]", d), 64'(busy[d]), 64'(cw[d] && pend));
    chk($sformatf("qh_cur[%0d]", d), 64'(qhc[d]), 64'(mqh[d]));
    if (busy[d]) busy_cnt[d]++;
    acc[d] = g;
    if (gi >= 0) begin
      e.dut = d;
      e.due = cyc + lat[d];
      e.id  = gi;
      e.c   = ref_sub(ra[d][gi*LQ +: LQ], rb[d][gi*LQ +: LQ], mqh[d]);
      expq.push_back(e);
      mptr[d]    = (gi + 1) % N;
      iss_cyc[d] = cyc;
    end
    cfg_done[d] = 0;
    if (cw[d] && !pend && !rst) begin
      mqh[d]      = cq[d];
      cfg_done[d] = 1;
    end
    foreach (expq[k]) if (expq[k].dut == d && expq[k].due == cyc) hit = k;
    chk($sformatf("res_valid[%0d]", d), 64'(resv[d]), 64'(hit >= 0));
    if (hit >= 0) begin
      chk($sformatf("res_id[%0d]", d), 64'(resid[d]), 64'(expq[hit].id));
      chk($sformatf("res_c[%0d]", d), resc[d], expq[hit].c);
      last_c[d]  = resc[d];
      last_id[d] = int'(resid[d]);
      res_cyc[d] = cyc;
      expq.delete(hit);
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 3; d++) check_dut(d);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      rv[d] = rv[d] & ~acc[d];
      if (cfg_done[d]) cw[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rv[d] = '0;
      cw[d] = 1'b0;
      mptr[d] = 0;
      mqh[d] = '0;
      acc[d] = '0;
      cfg_done[d] = 0;
    end
    expq.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue_op(int d, int i, logic [63:0] a, logic [63:0] b);
    ra[d][i*LQ +: LQ] = a;
    rb[d][i*LQ +: LQ] = b;
    rv[d][i] = 1'b1;
    last_c[d] = 64'hDEAD_BEEF;
    for (int t = 0; t < 50 && rv[d][i]; t++) step();
    if (rv[d][i]) begin
      tmo("issue_wait");
      rv[d][i] = 1'b0;
    end
  endtask

  task automatic do_cfg(int d, logic [LQH-1:0] qh);
    cq[d] = qh;
    cw[d] = 1'b1;
    for (int t = 0; t < 50 && cw[d]; t++) step();
    if (cw[d]) begin
      tmo("cfg_wait");
      cw[d] = 1'b0;
    end
  endtask

  task automatic drive_random();
    for (int d = 0; d < 3; d++) begin
      if (!cw[d] && rv[d] == '0 && $urandom_range(0, 39) == 0) begin
        cq[d] = rand_qh();
        cw[d] = 1'b1;
      end else if (!cw[d]) begin
        for (int i = 0; i < N; i++) begin
          if (!rv[d][i] && $urandom_range(0, 1) == 1) begin
            ra[d][i*LQ +: LQ] = rand_op(mqh[d]);
            rb[d][i*LQ +: LQ] = rand_op(mqh[d]);
            rv[d][i] = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit idle;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    lat[0] = 3;
    lat[1] = 0;
    lat[2] = 2;
    for (int d = 0; d < 3; d++) begin
      ra[d] = '0;
      rb[d] = '0;
      cq[d] = '0;
      busy_cnt[d] = 0;
    end
    do_reset();

    for (int d = 0; d < 3; d++) begin
      chk("rst_req_ready", 64'(rdy[d]), 64'd0);
      chk("rst_cfg_busy", 64'(busy[d]), 64'd0);
      chk("rst_res_valid", 64'(resv[d]), 64'd0);
      chk("rst_res_id", 64'(resid[d]), 64'd0);
      chk("rst_qh_cur", 64'(qhc[d]), 64'd0);
    end

    // Basic subtraction with q = 131073 on every latency configuration.
    for (int d = 0; d < 3; d++) do_cfg(d, LQH'(1));
    chk("qh_loaded", 64'(qhc[0]), 64'd1);
    for (int d = 0; d < 3; d++) begin
      issue_op(d, 0, 64'd5, 64'd3);
      repeat (4) step();
      chk("basic_c", last_c[d], 64'd2);
      chk("basic_id", 64'(last_id[d]), 64'd0);
      chk("basic_lat", 64'(res_cyc[d] - iss_cyc[d]), (d == 0) ? 64'd3 : (d == 1) ? 64'd0 : 64'd2);
    end

    issue_op(0, 2, 64'd3, 64'd5);
    repeat (4) step();
    chk("wrap_c", last_c[0], 64'd131071);
    chk("wrap_id", 64'(last_id[0]), 64'd2);
    issue_op(0, 3, 64'd0, 64'd0);
    repeat (4) step();
    chk("zero_c", last_c[0], 64'd0);

    // Round-robin with every requester asserting for 8 cycles.
    for (int i = 0; i < N; i++) begin
      ra[0][i*LQ +: LQ] = 64'(i * 1000 + 7);
      rb[0][i*LQ +: LQ] = 64'(i * 3000);
    end
    for (int k = 0; k < 8; k++) begin
      rv[0] = 4'hF;
      step();
      chk("rr_grant", 64'(acc[0]), 64'd1 << (k % 4));
    end
    rv[0] = '0;
    repeat (4) step();

    // Drain before reconfiguration: three ops in flight block the load for three cycles.
    rv[0] = 4'b0111;
    repeat (3) step();
    busy_cnt[0] = 0;
    do_cfg(0, LQH'(2));
    chk("drain_busy_cycles", 64'(busy_cnt[0]), 64'd3);
    chk("drain_qh", 64'(qhc[0]), 64'd2);
    issue_op(0, 1, 64'd3, 64'd5);
    repeat (4) step();
    chk("q2_wrap_c", last_c[0], 64'd262143);

    // Reset with two ops in flight.
    rv[0] = 4'b0011;
    repeat (2) step();
    do_reset();
    chk("midrst_qh", 64'(qhc[0]), 64'd0);
    repeat (4) step();
    rv[0] = 4'hF;
    #1;
    chk("midrst_first_grant", 64'(rdy[0]), 64'd1);
    repeat (6) step();

    for (int d = 0; d < 3; d++) do_cfg(d, rand_qh());
    repeat (3000) begin
      drive_random();
      step();
    end
    idle = 0;
    for (int t = 0; t < 300 && !idle; t++) begin
      step();
      idle = 1;
      for (int d = 0; d < 3; d++) if (rv[d] != '0 || cw[d]) idle = 0;
    end
    if (!idle) tmo("final_drain");
    repeat (5) step();
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
